// File: rtl/csi_sync_controller_if.sv
// csi_sync_controller_if
// Observed LTS and CSI AXI-Stream handshakes. The controller only watches
// these signals; the producer/consumer pair on the real streams drives them.
interface csi_sync_controller_if;
  logic lts_tvalid;
  logic lts_tready;
  logic lts_tlast;
  logic csi_tvalid;
  logic csi_tready;
  logic csi_tlast;

  // Side that drives the stream handshakes (stream endpoints / testbench)
  modport master (
    output lts_tvalid, lts_tready, lts_tlast,
    output csi_tvalid, csi_tready, csi_tlast
  );

  // Side that only observes the handshakes (the controller)
  modport slave (
    input lts_tvalid, lts_tready, lts_tlast,
    input csi_tvalid, csi_tready, csi_tlast
  );
endinterface

// File: rtl/csi_sync_controller.sv
// csi_sync_controller
// Software-armed acquisition scheduler for the CSI extraction chain. Gates
// and resets sync_short / sync_long, enforces per-stage sample timeouts,
// tracks the CSI frame drain up to its tlast and applies a re-arm holdoff.
// Optional statistics counters are built only when the macro
// CSI_SYNC_CTRL_STATS_EN is defined; otherwise both outputs read 0.
module csi_sync_controller #(
  parameter int SHORT_TIMEOUT   = 400,
  parameter int LONG_TIMEOUT    = 320,
  parameter int DRAIN_TIMEOUT   = 2048,
  parameter int HOLDOFF_SAMPLES = 200
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  arm_in,
  input  logic                  continuous_in,
  input  logic                  sample_valid_in,
  input  logic                  power_trigger_in,
  input  logic                  short_detected_in,
  csi_sync_controller_if.slave  obs,
  output logic                  short_en_out,
  output logic                  long_en_out,
  output logic                  short_rst_out,
  output logic                  long_rst_out,
  output logic [2:0]            state_out,
  output logic                  capture_done_out,
  output logic [31:0]           capture_count_out,
  output logic                  drain_error_out,
  output logic [15:0]           timeout_count_out,
  output logic [15:0]           abort_count_out
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_POWER = 3'd1,
    ST_SYNC_SHORT = 3'd2,
    ST_SYNC_LONG  = 3'd3,
    ST_DRAIN      = 3'd4,
    ST_HOLDOFF    = 3'd5
  } state_t;

  localparam logic [15:0] SHORT_LAST = 16'(SHORT_TIMEOUT - 1);
  localparam logic [15:0] LONG_LAST  = 16'(LONG_TIMEOUT - 1);
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_TIMEOUT - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(HOLDOFF_SAMPLES - 1);

  state_t      state;
  logic [15:0] cnt;

  logic lts_beat, csi_beat, cnt_tick;
  logic short_abort, short_tmo, long_abort, long_tmo, drain_tmo, holdoff_done;

  assign lts_beat = obs.lts_tvalid & obs.lts_tready & obs.lts_tlast;
  assign csi_beat = obs.csi_tvalid & obs.csi_tready & obs.csi_tlast;

  // Sample-paced stages count samples; DRAIN counts raw clock cycles.
  assign cnt_tick = (state == ST_DRAIN) ||
                    (sample_valid_in && (state == ST_SYNC_SHORT ||
                                         state == ST_SYNC_LONG  ||
                                         state == ST_HOLDOFF));

  // Exit conditions already qualified by the higher-priority ones
  // (disarm, detection / LTS tlast) so the stats see only real events.
  assign short_abort  = (state == ST_SYNC_SHORT) && arm_in && !short_detected_in && !power_trigger_in;
  assign short_tmo    = (state == ST_SYNC_SHORT) && arm_in && !short_detected_in && power_trigger_in &&
                        sample_valid_in && (cnt == SHORT_LAST);
  assign long_abort   = (state == ST_SYNC_LONG) && arm_in && !lts_beat && !power_trigger_in;
  assign long_tmo     = (state == ST_SYNC_LONG) && arm_in && !lts_beat && power_trigger_in &&
                        sample_valid_in && (cnt == LONG_LAST);
  assign drain_tmo    = (state == ST_DRAIN) && !csi_beat && (cnt == DRAIN_LAST);
  assign holdoff_done = (state == ST_HOLDOFF) && sample_valid_in && (cnt == HOLD_LAST);

  assign state_out    = state;
  assign short_en_out = (state == ST_SYNC_SHORT);
  assign long_en_out  = (state == ST_SYNC_LONG);

  // Acquisition FSM with its stage counter, pulses, capture count and drain error.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      short_rst_out     <= 1'b0;
      long_rst_out      <= 1'b0;
      capture_done_out  <= 1'b0;
      capture_count_out <= '0;
      drain_error_out   <= 1'b0;
    end else begin
      short_rst_out    <= 1'b0;
      long_rst_out     <= 1'b0;
      capture_done_out <= 1'b0;
      if (!arm_in) drain_error_out <= 1'b0;
      if (cnt_tick) cnt <= cnt + 16'd1;

      case (state)
        ST_IDLE: begin
          if (arm_in) begin
            state <= ST_WAIT_POWER;
            cnt   <= '0;
          end
        end
        ST_WAIT_POWER: begin
          if (!arm_in) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (power_trigger_in) begin
            state         <= ST_SYNC_SHORT;
            cnt           <= '0;
            short_rst_out <= 1'b1;
          end
        end
        ST_SYNC_SHORT: begin
          if (!arm_in) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (short_detected_in) begin
            state        <= ST_SYNC_LONG;
            cnt          <= '0;
            long_rst_out <= 1'b1;
          end else if (short_abort || short_tmo) begin
            state <= ST_WAIT_POWER;
            cnt   <= '0;
          end
        end
        ST_SYNC_LONG: begin
          if (!arm_in) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (lts_beat) begin
            state <= ST_DRAIN;
            cnt   <= '0;
          end else if (long_abort || long_tmo) begin
            state <= ST_WAIT_POWER;
            cnt   <= '0;
          end
        end
        ST_DRAIN: begin
          // Disarm is deferred here: the frame is allowed to finish or time out.
          if (csi_beat) begin
            capture_done_out  <= 1'b1;
            capture_count_out <= capture_count_out + 32'd1;
            state             <= (continuous_in && arm_in) ? ST_HOLDOFF : ST_IDLE;
            cnt               <= '0;
          end else if (drain_tmo) begin
            drain_error_out <= 1'b1;
            state           <= arm_in ? ST_WAIT_POWER : ST_IDLE;
            cnt             <= '0;
          end
        end
        ST_HOLDOFF: begin
          if (!arm_in) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (holdoff_done) begin
            state <= ST_WAIT_POWER;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef CSI_SYNC_CTRL_STATS_EN
  logic        timeout_evt, abort_evt;
  logic [15:0] timeout_cnt, abort_cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign timeout_evt = short_tmo | long_tmo | drain_tmo;
  assign abort_evt   = short_abort | long_abort;

  // Saturating event statistics, cleared only by reset.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      timeout_cnt <= '0;
      abort_cnt   <= '0;
    end else begin
      if (timeout_evt) timeout_cnt <= sat_inc(timeout_cnt);
      if (abort_evt)   abort_cnt   <= sat_inc(abort_cnt);
    end
  end

  assign timeout_count_out = timeout_cnt;
  assign abort_count_out   = abort_cnt;
`else
  assign timeout_count_out = '0;
  assign abort_count_out   = '0;
`endif

endmodule

// File: tb/tb_csi_sync_controller.sv
// tb_csi_sync_controller
// Directed scenarios plus a randomized soak, every cycle compared against a
// behavioural model of the acquisition sequence kept in this bench.
// Statistics expectations follow CSI_SYNC_CTRL_STATS_EN.
module tb_csi_sync_controller;
  localparam int ST = 400;
  localparam int LT = 320;
  localparam int DT = 2048;
  localparam int HS = 200;
`ifdef CSI_SYNC_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic arm_in = 1'b0, continuous_in = 1'b0, sample_valid_in = 1'b0;
  logic power_trigger_in = 1'b0, short_detected_in = 1'b0;
  logic short_en_out, long_en_out, short_rst_out, long_rst_out;
  logic [2:0]  state_out;
  logic        capture_done_out, drain_error_out;
  logic [31:0] capture_count_out;
  logic [15:0] timeout_count_out, abort_count_out;

  csi_sync_controller_if sif ();

  csi_sync_controller dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .arm_in            (arm_in),
    .continuous_in     (continuous_in),
    .sample_valid_in   (sample_valid_in),
    .power_trigger_in  (power_trigger_in),
    .short_detected_in (short_detected_in),
    .obs               (sif),
    .short_en_out      (short_en_out),
    .long_en_out       (long_en_out),
    .short_rst_out     (short_rst_out),
    .long_rst_out      (long_rst_out),
    .state_out         (state_out),
    .capture_done_out  (capture_done_out),
    .capture_count_out (capture_count_out),
    .drain_error_out   (drain_error_out),
    .timeout_count_out (timeout_count_out),
    .abort_count_out   (abort_count_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  // Stage codes as published on state_out.
  localparam int IDLE = 0, WAITP = 1, SSHORT = 2, SLONG = 3, DRAIN = 4, HOLD = 5;

  int          m_state;
  int          m_ticks;     // samples (or cycles in DRAIN) seen since entering the stage
  bit          m_srst, m_lrst, m_done, m_err;
  int unsigned m_caps;
  int          m_tmo, m_abt;

  function automatic void model_reset();
    m_state = IDLE; m_ticks = 0;
    m_srst = 0; m_lrst = 0; m_done = 0; m_err = 0;
    m_caps = 0; m_tmo = 0; m_abt = 0;
  endfunction

  // One clock of the sequencing rules, applied to the inputs present at the edge.
  function automatic void model_step();
    bit lts, csi, sv, timed_out, aborted;
    int nxt;
    if (!rst_n_in) begin
      model_reset();
      return;
    end
    lts = sif.lts_tvalid && sif.lts_tready && sif.lts_tlast;
    csi = sif.csi_tvalid && sif.csi_tready && sif.csi_tlast;
    sv  = sample_valid_in;
    nxt = m_state; timed_out = 0; aborted = 0;
    m_srst = 0; m_lrst = 0; m_done = 0;
    if (!arm_in) m_err = 0;
    if (m_state == DRAIN) begin
      if (csi) begin
        m_done = 1; m_caps++;
        nxt = (continuous_in && arm_in) ? HOLD : IDLE;
      end else if (m_ticks + 1 == DT) begin
        m_err = 1; timed_out = 1;
        nxt = arm_in ? WAITP : IDLE;
      end
    end else if (m_state == IDLE) begin
      if (arm_in) nxt = WAITP;
    end else if (!arm_in) begin
      nxt = IDLE;
    end else if (m_state == WAITP) begin
      if (power_trigger_in) begin nxt = SSHORT; m_srst = 1; end
    end else if (m_state == SSHORT) begin
      if (short_detected_in) begin nxt = SLONG; m_lrst = 1; end
      else if (!power_trigger_in) begin nxt = WAITP; aborted = 1; end
      else if (sv && m_ticks + 1 == ST) begin nxt = WAITP; timed_out = 1; end
    end else if (m_state == SLONG) begin
      if (lts) nxt = DRAIN;
      else if (!power_trigger_in) begin nxt = WAITP; aborted = 1; end
      else if (sv && m_ticks + 1 == LT) begin nxt = WAITP; timed_out = 1; end
    end else if (m_state == HOLD) begin
      if (sv && m_ticks + 1 == HS) nxt = WAITP;
    end
    if (timed_out && m_tmo < 65535) m_tmo++;
    if (aborted && m_abt < 65535) m_abt++;
    if (nxt != m_state) m_ticks = 0;
    else if (m_state == DRAIN || (sv && (m_state == SSHORT || m_state == SLONG || m_state == HOLD)))
      m_ticks++;
    m_state = nxt;
  endfunction

  task automatic compare_all();
    chk("ctrl", {state_out, short_en_out, long_en_out, short_rst_out, long_rst_out,
                 capture_done_out, drain_error_out},
                {3'(m_state), m_state == SSHORT, m_state == SLONG, m_srst, m_lrst, m_done, m_err});
    chk("capture_count", capture_count_out, m_caps);
    chk("stats", {timeout_count_out, abort_count_out},
                 STATS ? {16'(m_tmo), 16'(m_abt)} : 32'd0);
  endtask

  // ---------------- stimulus helpers ----------------
  int sv_period = 0;
  int cyc = 0;
  int ho_samples = 0;

  task automatic step();
    sample_valid_in = (sv_period > 0) ? (cyc % sv_period == 0) : ($urandom_range(0, 2) == 0);
    cyc++;
    if (state_out == 3'd5 && sample_valid_in) ho_samples++;
    @(posedge clk_in);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic wait_state(input string tag, input logic [2:0] tgt, input int max);
    int n = 0;
    while (state_out !== tgt && n < max) begin
      step();
      n++;
    end
    chk(tag, state_out, tgt);
  endtask

  task automatic lts_beat();
    sif.lts_tvalid = 1; sif.lts_tready = 1; sif.lts_tlast = 1;
    step();
    sif.lts_tvalid = 0; sif.lts_tready = 0; sif.lts_tlast = 0;
  endtask

  task automatic csi_beat();
    sif.csi_tvalid = 1; sif.csi_tready = 1; sif.csi_tlast = 1;
    step();
    sif.csi_tvalid = 0; sif.csi_tready = 0; sif.csi_tlast = 0;
  endtask

  task automatic pulse_detect();
    short_detected_in = 1;
    step();
    short_detected_in = 0;
  endtask

  initial begin
    sif.lts_tvalid = 0; sif.lts_tready = 0; sif.lts_tlast = 0;
    sif.csi_tvalid = 0; sif.csi_tready = 0; sif.csi_tlast = 0;
    model_reset();
    #2;
    compare_all();
    chk("reset_state", state_out, 3'd0);
    repeat (2) step();
    rst_n_in = 1;

    // Full single-shot capture
    arm_in = 1; continuous_in = 0; power_trigger_in = 1;
    wait_state("s1_sync_short", 3'd2, 10);
    begin
      int n = 0;
      while (m_ticks < 50 && n < 1000) begin step(); n++; end
    end
    pulse_detect();
    chk("s1_long_rst", {long_rst_out, long_en_out, short_en_out}, 3'b110);
    repeat (20) step();
    lts_beat();
    chk("s1_drain", state_out, 3'd4);
    for (int i = 0; i < 300; i++) begin
      power_trigger_in = $urandom_range(0, 1);
      step();
    end
    chk("s1_drain_hold", state_out, 3'd4);
    power_trigger_in = 1;
    csi_beat();
    chk("s1_done", {capture_done_out, state_out}, {1'b1, 3'd0});
    chk("s1_count", capture_count_out, 32'd1);

    // Short timeout with power held high
    wait_state("s2_sync_short", 3'd2, 10);
    wait_state("s2_timeout", 3'd1, 3000);
    step();
    chk("s2_reenter", {state_out, short_rst_out}, {3'd2, 1'b1});
    chk("s2_tmo_count", timeout_count_out, STATS ? 16'd1 : 16'd0);

    // Power drop in SYNC_LONG, then same-cycle priority cases
    pulse_detect();
    begin
      int n = 0;
      while (m_ticks < 100 && n < 1000) begin step(); n++; end
    end
    power_trigger_in = 0;
    step();
    chk("s3_abort", {state_out, long_en_out}, {3'd1, 1'b0});
    chk("s3_abort_count", abort_count_out, STATS ? 16'd1 : 16'd0);
    power_trigger_in = 1;
    wait_state("s3_sync_short", 3'd2, 10);
    power_trigger_in = 0;
    pulse_detect();
    chk("s3_detect_wins", state_out, 3'd3);
    power_trigger_in = 1;
    repeat (5) step();
    power_trigger_in = 0;
    lts_beat();
    chk("s3_lts_wins", state_out, 3'd4);
    chk("s3_abort_unchanged", abort_count_out, STATS ? 16'd1 : 16'd0);
    repeat (10) step();
    csi_beat();
    power_trigger_in = 1;

    // Continuous mode, two frames with sample_valid every 6th cycle
    continuous_in = 1; sv_period = 6;
    for (int f = 0; f < 2; f++) begin
      wait_state("s4_sync_short", 3'd2, 20);
      pulse_detect();
      repeat (5) step();
      lts_beat();
      repeat (10) step();
      csi_beat();
      chk("s4_holdoff", state_out, 3'd5);
      if (f == 0) begin
        int n = 0;
        ho_samples = 0;
        while (state_out == 3'd5 && n < 2000) begin step(); n++; end
        chk("s4_holdoff_samples", ho_samples, 200);
        chk("s4_holdoff_cycles", (n >= 1195 && n <= 1200), 1'b1);
        chk("s4_after_holdoff", state_out, 3'd1);
      end else begin
        repeat (30) step();
        arm_in = 0;
        step();
        chk("s4_disarm", state_out, 3'd0);
      end
    end
    chk("s4_count", capture_count_out, 32'd4);

    // DRAIN timeout, error clear, deferred disarm
    continuous_in = 0; sv_period = 0; arm_in = 1;
    wait_state("s5_sync_short", 3'd2, 10);
    pulse_detect();
    lts_beat();
    chk("s5_drain", state_out, 3'd4);
    begin
      int n = 0;
      while (state_out == 3'd4 && n < 2100) begin
        sif.csi_tvalid = $urandom_range(0, 1);
        sif.csi_tlast  = $urandom_range(0, 1);
        sif.csi_tready = (sif.csi_tvalid && sif.csi_tlast) ? 1'b0 : 1'($urandom_range(0, 1));
        step();
        n++;
      end
      chk("s5_drain_cycles", n, DT);
    end
    sif.csi_tvalid = 0; sif.csi_tready = 0; sif.csi_tlast = 0;
    chk("s5_tmo_state", {state_out, drain_error_out}, {3'd1, 1'b1});
    chk("s5_tmo_count", timeout_count_out, STATS ? 16'd2 : 16'd0);
    arm_in = 0;
    step();
    chk("s5_err_clear", {drain_error_out, state_out}, {1'b0, 3'd0});
    arm_in = 1;
    wait_state("s5_sync_short2", 3'd2, 10);
    pulse_detect();
    lts_beat();
    repeat (20) step();
    arm_in = 0;
    repeat (20) step();
    chk("s5_disarm_deferred", state_out, 3'd4);
    csi_beat();
    chk("s5_late_capture", {capture_done_out, state_out}, {1'b1, 3'd0});
    chk("s5_count", capture_count_out, 32'd5);

    // Reset mid SYNC_LONG
    arm_in = 1;
    wait_state("s6_sync_short", 3'd2, 10);
    pulse_detect();
    repeat (5) step();
    #2;
    rst_n_in = 0; arm_in = 0;
    #1;
    model_reset();
    compare_all();
    chk("s6_reset_now", {state_out, long_en_out, capture_count_out}, 36'd0);
    repeat (3) step();
    rst_n_in = 1;
    repeat (5) step();
    chk("s6_idle_held", state_out, 3'd0);

    // Randomized soak
    for (int i = 0; i < 6000; i++) begin
      arm_in            = ($urandom_range(0, 99) < 97);
      continuous_in     = $urandom_range(0, 1);
      power_trigger_in  = ($urandom_range(0, 99) < 95);
      short_detected_in = ($urandom_range(0, 99) < 3);
      sif.lts_tvalid    = ($urandom_range(0, 1) == 1);
      sif.lts_tready    = ($urandom_range(0, 9) < 7);
      sif.lts_tlast     = ($urandom_range(0, 9) < 2);
      sif.csi_tvalid    = ($urandom_range(0, 1) == 1);
      sif.csi_tready    = ($urandom_range(0, 9) < 7);
      sif.csi_tlast     = ($urandom_range(0, 99) < 2);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
